// File: rtl/tile_select_arbiter.sv
// Debounces the tile switches, latches each press as a pending tile request, and
// offers pending, unmatched tiles round-robin to the game FSM over valid/ready.
module tile_select_arbiter #(
  parameter int N_TILES         = 10,
  parameter int IDX_W           = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic               CLOCK_50,
  input  logic               userquit,
  input  logic [N_TILES-1:0] SW,
  input  logic [N_TILES-1:0] matched_mask,
  input  logic               enable,
  input  logic               sel_ready,
  output logic               sel_valid,
  output logic [IDX_W-1:0]   sel_idx,
  output logic [N_TILES-1:0] pending,
  output logic [N_TILES-1:0] sw_db
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [IDX_W:0]   N_EXT    = (IDX_W + 1)'(N_TILES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TILES - 1);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t             state, state_n;
  logic [N_TILES-1:0] sync_meta, sync_q;
  logic [N_TILES-1:0] sw_db_d;
  logic [CNT_W-1:0]   db_cnt [N_TILES];
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_n, sel_idx_n, pick_idx;
  logic [N_TILES-1:0] pending_n, avail, press;
  logic               pick_found, handshake;

  // NOTE: sequential state is written with non-blocking (<=) so every flop samples
  // pre-edge values; blocking (=) here would make results depend on block order.
  always_ff @(posedge CLOCK_50 or posedge userquit) begin
    if (userquit) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= SW;
      sync_q    <= sync_meta;
    end
  end

  // NOTE: the per-bit counter array is small and must start from zero for the
  // debounce latency to hold, so it is reset like any other register.
  always_ff @(posedge CLOCK_50 or posedge userquit) begin
    if (userquit) begin
      for (int i = 0; i < N_TILES; i++) db_cnt[i] <= '0;
      sw_db   <= '0;
      sw_db_d <= '0;
    end else begin
      sw_db_d <= sw_db;
      for (int i = 0; i < N_TILES; i++) begin
        if (sync_q[i] == sw_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_MAX) begin
          sw_db[i]  <= sync_q[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press     = sw_db & ~sw_db_d;
  assign avail     = pending & ~matched_mask;
  assign sel_valid = (state == OFFER);

  // NOTE: every variable driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    logic [IDX_W:0] cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < N_TILES; k++) begin
      cand = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
      if (cand >= N_EXT) cand = cand - N_EXT;
      if (!pick_found && avail[cand[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_n   = state;
    sel_idx_n = sel_idx;
    rr_ptr_n  = rr_ptr;
    handshake = 1'b0;
    case (state)
      IDLE: begin
        if (enable && pick_found) begin
          state_n   = OFFER;
          sel_idx_n = pick_idx;
        end
      end
      OFFER: begin
        // Withdrawal beats a same-cycle ready so a matched tile is never granted.
        if (!enable || matched_mask[sel_idx]) begin
          state_n = IDLE;
        end else if (sel_ready) begin
          handshake = 1'b1;
          state_n   = IDLE;
          rr_ptr_n  = (sel_idx == LAST_IDX) ? '0 : sel_idx + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    pending_n = pending & ~matched_mask;
    if (handshake) pending_n[sel_idx] = 1'b0;
    pending_n = pending_n | (press & ~matched_mask);
  end

  always_ff @(posedge CLOCK_50 or posedge userquit) begin
    if (userquit) begin
      state   <= IDLE;
      sel_idx <= '0;
      rr_ptr  <= '0;
      pending <= '0;
    end else begin
      state   <= state_n;
      sel_idx <= sel_idx_n;
      rr_ptr  <= rr_ptr_n;
      pending <= pending_n;
    end
  end

endmodule

// File: tb/tb_tile_select_arbiter.sv
// Randomized and directed bench for tile_select_arbiter against a cycle-level
// behavioural model of switch history, debounce run lengths and round-robin pick.
module tb_tile_select_arbiter;

  localparam int N  = 10;
  localparam int IW = 4;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          userquit;
  logic [N-1:0]  sw, mm;
  logic          en, rdy;
  logic          sel_valid;
  logic [IW-1:0] sel_idx;
  logic [N-1:0]  pending, sw_db;

  int total = 0;
  int bad   = 0;

  // behavioural model state
  bit [N-1:0] m_h1, m_h2, m_db, m_db_last, m_pend;
  int         m_run [N];
  bit         m_off;
  int         m_idx, m_rr;

  tile_select_arbiter #(.N_TILES(N), .IDX_W(IW), .DEBOUNCE_CYCLES(D)) dut (
    .CLOCK_50    (clk),
    .userquit    (userquit),
    .SW          (sw),
    .matched_mask(mm),
    .enable      (en),
    .sel_ready   (rdy),
    .sel_valid   (sel_valid),
    .sel_idx     (sel_idx),
    .pending     (pending),
    .sw_db       (sw_db)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_h1 = '0; m_h2 = '0; m_db = '0; m_db_last = '0; m_pend = '0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
    m_off = 1'b0; m_idx = 0; m_rr = 0;
  endtask

  // One rising edge of the model, evaluated from the inputs held before the edge.
  task automatic model_step();
    bit [N-1:0] rise, db_next, pend_next;
    bit         hs;
    rise    = m_db & ~m_db_last;
    db_next = m_db;
    for (int i = 0; i < N; i++) begin
      if (m_h2[i] != m_db[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          db_next[i] = m_h2[i];
          m_run[i]   = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    hs = m_off && en && !mm[m_idx] && rdy;
    pend_next = m_pend & ~mm;
    if (hs) pend_next[m_idx] = 1'b0;
    pend_next = pend_next | (rise & ~mm);
    if (m_off) begin
      if (!en || mm[m_idx]) begin
        m_off = 1'b0;
      end else if (rdy) begin
        m_rr  = (m_idx + 1) % N;
        m_off = 1'b0;
      end
    end else if (en) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_rr + k) % N;
        if (!m_off && m_pend[j] && !mm[j]) begin
          m_off = 1'b1;
          m_idx = j;
        end
      end
    end
    m_pend    = pend_next;
    m_db_last = m_db;
    m_db      = db_next;
    m_h2      = m_h1;
    m_h1      = sw;
  endtask

  // Inputs change only in the negedge phase; outputs are compared 1 ns after posedge.
  task automatic tick();
    @(posedge clk);
    if (userquit) model_reset();
    else model_step();
    #1;
    check("m_valid",   32'(sel_valid), 32'(m_off));
    check("m_idx",     32'(sel_idx),   32'(m_idx));
    check("m_pending", 32'(pending),   32'(m_pend));
    check("m_sw_db",   32'(sw_db),     32'(m_db));
    @(negedge clk);
  endtask

  task automatic do_reset();
    sw = '0; mm = '0; en = 1'b0; rdy = 1'b0;
    userquit = 1'b1;
    model_reset();
    tick();
    tick();
    userquit = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!sel_valid && n < 40) begin
      tick();
      n++;
    end
    check(tag, 32'(sel_valid), 32'd1);
  endtask

  task automatic collect_grants(output int g[$], output int t[$]);
    g = {};
    t = {};
    for (int c = 0; c < 40; c++) begin
      tick();
      if (sel_valid) begin
        g.push_back(int'(sel_idx));
        t.push_back(c);
      end
    end
  endtask

  initial begin
    int g[$], t[$];
    int n, seen, r;
    int exp_a[3] = '{0, 5, 9};
    int exp_b[2] = '{0, 9};

    userquit = 1'b1;
    sw = '0; mm = '0; en = 1'b0; rdy = 1'b0;
    @(negedge clk);
    do_reset();
    check("rst_valid",   32'(sel_valid), 32'd0);
    check("rst_idx",     32'(sel_idx),   32'd0);
    check("rst_pending", 32'(pending),   32'd0);
    check("rst_sw_db",   32'(sw_db),     32'd0);

    // Bounce on SW[3]
    en = 1'b1; rdy = 1'b0; seen = 0;
    for (int p = 0; p < 6; p++) begin
      sw[3] = ~sw[3];
      tick(); tick();
      seen |= int'(sw_db[3]);
    end
    check("bounce_no_early", 32'(seen), 32'd0);
    sw[3] = 1'b1;
    n = 0;
    while (!sw_db[3] && n < 20) begin
      tick();
      n++;
    end
    check("bounce_latency", 32'(n), 32'd6);
    tick();
    check("bounce_pending", 32'(pending), 32'h008);
    wait_valid("bounce_offer");
    check("bounce_idx", 32'(sel_idx), 32'd3);
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    check("bounce_grant_valid", 32'(sel_valid), 32'd0);
    check("bounce_grant_pending", 32'(pending), 32'd0);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      seen |= int'(sel_valid);
    end
    check("bounce_single_offer", 32'(seen), 32'd0);

    // Round-robin
    do_reset();
    en = 1'b1; rdy = 1'b1; sw = 10'h221;
    collect_grants(g, t);
    check("rr_a_count", 32'(g.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      check($sformatf("rr_a_grant%0d", k), 32'((k < g.size()) ? g[k] : 99), 32'(exp_a[k]));
    check("rr_a_spacing", 32'((t.size() > 1) ? t[1] - t[0] : 0), 32'd2);
    check("rr_a_pending", 32'(pending), 32'd0);
    sw = '0;
    for (int c = 0; c < 10; c++) tick();
    sw = 10'h201;
    collect_grants(g, t);
    check("rr_b_count", 32'(g.size()), 32'd2);
    for (int k = 0; k < 2; k++)
      check($sformatf("rr_b_grant%0d", k), 32'((k < g.size()) ? g[k] : 99), 32'(exp_b[k]));

    // Matched mask
    do_reset();
    mm = 10'h004; en = 1'b1; rdy = 1'b0; sw = 10'h004; seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      seen |= int'(sel_valid);
    end
    check("mask_no_offer", 32'(seen), 32'd0);
    check("mask_pending", 32'(pending), 32'd0);
    sw = 10'h084;
    wait_valid("mask_offer7");
    check("mask_idx7", 32'(sel_idx), 32'd7);
    mm = 10'h084;
    tick();
    check("mask_withdraw", 32'(sel_valid), 32'd0);
    check("mask_pend7", 32'(pending[7]), 32'd0);
    mm = '0;

    // Enable drop
    do_reset();
    sw = 10'h010; en = 1'b1; rdy = 1'b0;
    wait_valid("en_offer");
    check("en_idx", 32'(sel_idx), 32'd4);
    en = 1'b0;
    tick();
    check("en_drop_valid", 32'(sel_valid), 32'd0);
    check("en_drop_pend4", 32'(pending[4]), 32'd1);
    en = 1'b1;
    tick();
    check("en_reoffer_valid", 32'(sel_valid), 32'd1);
    check("en_reoffer_idx", 32'(sel_idx), 32'd4);
    rdy = 1'b1;
    tick();
    rdy = 1'b0;

    // Set wins over a same-cycle handshake clear
    do_reset();
    sw = 10'h002; en = 1'b1; rdy = 1'b0;
    wait_valid("sw_offer");
    check("sw_idx", 32'(sel_idx), 32'd1);
    sw = '0;
    n = 0;
    while (sw_db[1] && n < 20) begin tick(); n++; end
    check("sw_release", 32'(sw_db[1]), 32'd0);
    sw = 10'h002;
    n = 0;
    while (!sw_db[1] && n < 20) begin tick(); n++; end
    check("sw_repress", 32'(sw_db[1]), 32'd1);
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    check("sw_hs_valid", 32'(sel_valid), 32'd0);
    check("sw_set_wins", 32'(pending[1]), 32'd1);

    // Asynchronous reset mid-offer
    do_reset();
    sw = 10'h040; en = 1'b1; rdy = 1'b0;
    wait_valid("ar_offer");
    check("ar_idx", 32'(sel_idx), 32'd6);
    #2;
    userquit = 1'b1;
    model_reset();
    #1;
    check("ar_valid", 32'(sel_valid), 32'd0);
    check("ar_pending", 32'(pending), 32'd0);
    check("ar_sw_db", 32'(sw_db), 32'd0);
    check("ar_idx0", 32'(sel_idx), 32'd0);
    sw = '0;
    tick();
    userquit = 1'b0;
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      seen |= int'(sel_valid);
    end
    check("ar_no_offer", 32'(seen), 32'd0);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) begin
        r = int'($urandom_range(N - 1));
        sw[r] = ~sw[r];
      end
      if ($urandom_range(63) == 0) begin
        r = int'($urandom_range(N - 1));
        mm[r] = 1'b1;
      end
      if ($urandom_range(47) == 0) mm = '0;
      en  = ($urandom_range(9) != 0);
      rdy = $urandom_range(1) == 1;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
